param_accum_processor: RTL and testbench

//  Parametrised accumulator processor: control FSM, datapath and program/data RAM in one block.
//  8-opcode ISA (load/store/add/sub/input/jump-zero/jump-positive/halt) with a handshaked input.

---
 rtl/param_accum_processor.sv | 211 +++++++++++++++++++++
 tb/tb_param_accum_processor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_accum_processor.sv
`default_nettype none
// ============================================================================
//  Module      : param_accum_processor
//  Description : Accumulator processor with an 8-opcode ISA. The control FSM,
//                datapath and a unified program/data RAM are all in this one
//                block. The RAM is loaded through a program port while the
//                core is held in reset.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    accumulator / memory word / dataIn / dataOut width
//              (must be >= ADDR_W+3)
//    ADDR_W    address width; memory depth = 2**ADDR_W words
//  Ports
//    clock     in   1       rising-edge clock
//    reset     in   1       synchronous, active-low reset
//    dataIn    in   DATA_W  operand for IN
//    enter     in   1       IN handshake level; its rising edge completes IN
//    prog_we   in   1       program-load write strobe (only while reset==0)
//    prog_addr in   ADDR_W  program-load address
//    prog_data in   DATA_W  program-load data
//    dataOut   out  DATA_W  accumulator A
//    Halt      out  1       high once HALT has executed
//    IR        out  3       opcode of the current instruction
//    pc        out  ADDR_W  program counter
//    in_wait   out  1       high while an IN waits for an enter edge
//    ovf       out  1       sticky signed overflow of ADD/SUB
//                           (only when PARAM_ACCUM_OVF_EN is defined)
//  Configuration macro
//    PARAM_ACCUM_OVF_EN     adds the ovf port and its overflow logic
//  Instruction word: opcode = bits[DATA_W-1:DATA_W-3], addr = bits[ADDR_W-1:0]
// ============================================================================
module param_accum_processor #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              enter,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] dataOut,
    output logic              Halt,
    output logic [2:0]        IR,
    output logic [ADDR_W-1:0] pc,
    output logic              in_wait
`ifdef PARAM_ACCUM_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [1:0]        state;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] pc_r;
    logic [2:0]        fetched_op;    // opcode captured at FETCH
    logic [ADDR_W-1:0] fetched_addr;  // operand address captured at FETCH
    logic [2:0]        ir_op;         // opcode visible on IR from DECODE on
    logic [ADDR_W-1:0] opnd_addr;     // operand address used in EXEC
    logic              halt_r;
    logic              enter_q;

    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              enter_rise;
    logic              in_exec;

    // Asynchronous memory read for the operand
    assign operand    = mem[opnd_addr];
    assign sum        = acc + operand;
    assign diff       = acc - operand;
    assign enter_rise = enter & ~enter_q;
    assign in_exec    = (state == ST_EXEC) && (ir_op == OP_IN);

    assign dataOut = acc;
    assign Halt    = halt_r;
    assign IR      = ir_op;
    assign pc      = pc_r;
    // Drops in the same cycle the accepted edge is present
    assign in_wait = in_exec && !enter_rise;

    // ------------------------------------------------------------------
    // Memory write port. The program port owns the RAM while the core is
    // in reset; STORE owns it otherwise. A reset in the cycle a STORE
    // would execute aborts the write. Contents are never cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (prog_we) begin
                mem[prog_addr] <= prog_data;
            end
        end else if ((state == ST_EXEC) && (ir_op == OP_STORE)) begin
            mem[opnd_addr] <= acc;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_FETCH;
            acc          <= '0;
            pc_r         <= '0;
            fetched_op   <= '0;
            fetched_addr <= '0;
            ir_op        <= '0;
            opnd_addr    <= '0;
            halt_r       <= 1'b0;
            enter_q      <= 1'b0;
        end else begin
            enter_q <= enter;
            case (state)
                ST_FETCH: begin
                    fetched_op   <= mem[pc_r][DATA_W-1 -: 3];
                    fetched_addr <= mem[pc_r][ADDR_W-1:0];
                    pc_r         <= pc_r + ADDR_W'(1);  // natural wrap
                    state        <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_op     <= fetched_op;
                    opnd_addr <= fetched_addr;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (ir_op)
                        OP_LOAD: acc <= operand;
                        OP_ADD:  acc <= sum;
                        OP_SUB:  acc <= diff;
                        OP_IN: begin
                            if (enter_rise) begin
                                acc <= dataIn;
                            end else begin
                                state <= ST_EXEC;
                            end
                        end
                        OP_JZ: begin
                            if (acc == '0) begin
                                pc_r <= opnd_addr;
                            end
                        end
                        OP_JPOS: begin
                            // Strictly positive as a signed value
                            if (!acc[DATA_W-1] && (acc != '0)) begin
                                pc_r <= opnd_addr;
                            end
                        end
                        OP_HALT: begin
                            halt_r <= 1'b1;
                            state  <= ST_HALT;
                        end
                        default: ;  // STORE handled by the memory write port
                    endcase
                end
                ST_HALT: ;  // absorbing until reset
                default: state <= ST_FETCH;
            endcase
        end
    end

`ifdef PARAM_ACCUM_OVF_EN
    // ------------------------------------------------------------------
    // Sticky signed overflow: operands of equal sign (ADD) or differing
    // sign (SUB) producing a result whose sign differs from A.
    // ------------------------------------------------------------------
    logic ovf_r;
    logic add_ovf;
    logic sub_ovf;

    assign add_ovf = (acc[DATA_W-1] == operand[DATA_W-1]) &&
                     (sum[DATA_W-1] != acc[DATA_W-1]);
    assign sub_ovf = (acc[DATA_W-1] != operand[DATA_W-1]) &&
                     (diff[DATA_W-1] != acc[DATA_W-1]);

    always_ff @(posedge clock) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (state == ST_EXEC) begin
            if (((ir_op == OP_ADD) && add_ovf) || ((ir_op == OP_SUB) && sub_ovf)) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign ovf = ovf_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_accum_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_accum_processor
//  Description : Directed self-checking bench for param_accum_processor
//                (DATA_W=8, ADDR_W=5). Programs are loaded through the
//                program port while reset is held, then run for a known
//                number of cycles and the outputs compared to hand-computed
//                values. Honours PARAM_ACCUM_OVF_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_accum_processor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       enter = 1'b0;
    logic       prog_we = 1'b0;
    logic [4:0] prog_addr = 5'd0;
    logic [7:0] prog_data = 8'h00;
    logic [7:0] dataOut;
    logic       Halt;
    logic [2:0] IR;
    logic [4:0] pc;
    logic       in_wait;
`ifdef PARAM_ACCUM_OVF_EN
    logic       ovf;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int wait_cnt;

    param_accum_processor #(
        .DATA_W(8),
        .ADDR_W(5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .dataIn    (dataIn),
        .enter     (enter),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .dataOut   (dataOut),
        .Halt      (Halt),
        .IR        (IR),
        .pc        (pc),
        .in_wait   (in_wait)
`ifdef PARAM_ACCUM_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Program-port write; caller holds reset low
    task automatic wr(input int a, input logic [7:0] d);
        prog_addr = a[4:0];
        prog_data = d;
        prog_we   = 1'b1;
        tick(1);
        prog_we   = 1'b0;
    endtask

    function automatic logic [7:0] ins(input logic [2:0] op, input int a);
        return {op, a[4:0]};
    endfunction

    initial begin
        tick(2);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_pc", pc, 0);
        chk("rst_IR", IR, 0);
        chk("rst_Halt", Halt, 0);
        chk("rst_in_wait", in_wait, 0);

        // ---- 1: LOAD 30 / ADD 31 / STORE 29 / HALT ----
        wr(0, ins(3'd0, 30)); wr(1, ins(3'd2, 31)); wr(2, ins(3'd1, 29)); wr(3, ins(3'd7, 0));
        wr(30, 8'd5); wr(31, 8'd7);
        reset = 1'b1;
        tick(11);
        chk("t1_halt_c11", Halt, 0);
        tick(1);
        chk("t1_halt_c12", Halt, 1);
        chk("t1_dataOut", dataOut, 12);
        chk("t1_pc", pc, 4);
        chk("t1_IR", IR, 7);
        tick(5);
        chk("t1_pc_frozen", pc, 4);
        chk("t1_acc_frozen", dataOut, 12);
        // mem[29] read back by a second program; survives reset
        reset = 1'b0;
        wr(0, ins(3'd0, 29)); wr(1, ins(3'd7, 0));
        reset = 1'b1;
        tick(3);
        chk("t1_mem29", dataOut, 12);

        // ---- 2: IN / IN / HALT with handshake ----
        reset = 1'b0;
        wr(0, ins(3'd4, 0)); wr(1, ins(3'd4, 0)); wr(2, ins(3'd7, 0));
        dataIn = 8'hA5;
        reset = 1'b1;
        tick(2);
        wait_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_wait) wait_cnt++;
            tick(1);
        end
        chk("t2_wait_low", wait_cnt, 20);
        enter = 1'b1;
        #1;
        chk("t2_wait_drop", in_wait, 0);
        tick(1);
        chk("t2_acc_A5", dataOut, 8'hA5);
        tick(9);
        chk("t2_single_wait", in_wait, 1);
        chk("t2_single_pc", pc, 2);
        chk("t2_single_acc", dataOut, 8'hA5);
        chk("t2_single_halt", Halt, 0);
        enter = 1'b0;
        tick(1);
        dataIn = 8'h3C;
        enter = 1'b1;
        tick(1);
        chk("t2_acc_3C", dataOut, 8'h3C);
        tick(3);
        chk("t2_halt", Halt, 1);
        enter = 1'b0;

        // ---- 3: countdown loop ----
        reset = 1'b0;
        wr(0, ins(3'd0, 20)); wr(1, ins(3'd3, 21)); wr(2, ins(3'd5, 4));
        wr(3, ins(3'd6, 1)); wr(4, ins(3'd7, 0)); wr(20, 8'd3); wr(21, 8'd1);
        reset = 1'b1;
        tick(6);
        chk("t3_first_sub", dataOut, 2);
        tick(6);
        chk("t3_jpos_taken", pc, 1);
        tick(17);
        chk("t3_halt_c29", Halt, 0);
        chk("t3_acc_zero", dataOut, 0);
        tick(1);
        chk("t3_halt_c30", Halt, 1);
        chk("t3_pc_after_jz", pc, 5);
        // JPOS with A=0x80 is not taken
        reset = 1'b0;
        wr(0, ins(3'd0, 20)); wr(1, ins(3'd6, 5)); wr(2, ins(3'd7, 0));
        wr(5, ins(3'd7, 0)); wr(20, 8'h80);
        reset = 1'b1;
        tick(9);
        chk("t3_jpos80_halt", Halt, 1);
        chk("t3_jpos80_pc", pc, 3);

        // ---- 4: pc wrap, stray enter edge ----
        reset = 1'b0;
        wr(0, ins(3'd0, 20)); wr(1, ins(3'd5, 31)); wr(31, ins(3'd2, 21));
        wr(20, 8'h00); wr(21, 8'h11);
        reset = 1'b1;
        tick(6);
        chk("t4_pc31", pc, 31);
        tick(1);
        chk("t4_pc_wrap", pc, 0);
        tick(2);
        chk("t4_add_at31", dataOut, 8'h11);
        reset = 1'b0;
        wr(0, ins(3'd2, 20)); wr(1, ins(3'd4, 0)); wr(20, 8'd1);
        dataIn = 8'h77;
        reset = 1'b1;
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(4);
        chk("t4_stray_wait", in_wait, 1);
        tick(3);
        chk("t4_stray_still", in_wait, 1);
        chk("t4_stray_acc", dataOut, 1);

        // ---- 5: reset mid-IN and mid-STORE ----
        reset = 1'b0;
        wr(0, ins(3'd0, 20)); wr(1, ins(3'd4, 0)); wr(20, 8'h42);
        reset = 1'b1;
        tick(5);
        chk("t5_in_wait", in_wait, 1);
        chk("t5_acc_pre", dataOut, 8'h42);
        reset = 1'b0;
        tick(1);
        chk("t5_rst_dataOut", dataOut, 0);
        chk("t5_rst_pc", pc, 0);
        chk("t5_rst_IR", IR, 0);
        chk("t5_rst_Halt", Halt, 0);
        chk("t5_rst_in_wait", in_wait, 0);
        wr(1, ins(3'd1, 22)); wr(2, ins(3'd7, 0)); wr(22, 8'h99);
        reset = 1'b1;
        tick(5);
        chk("t5_store_exec", IR, 1);
        reset = 1'b0;
        tick(1);
        wr(0, ins(3'd0, 22)); wr(1, ins(3'd7, 0));
        reset = 1'b1;
        tick(3);
        chk("t5_store_aborted", dataOut, 8'h99);
        reset = 1'b0;
        wr(0, ins(3'd0, 20)); wr(1, ins(3'd1, 22)); wr(2, ins(3'd7, 0));
        reset = 1'b1;
        tick(6);
        reset = 1'b0;
        tick(1);
        wr(0, ins(3'd0, 22)); wr(1, ins(3'd7, 0));
        reset = 1'b1;
        tick(3);
        chk("t5_store_done", dataOut, 8'h42);

`ifdef PARAM_ACCUM_OVF_EN
        // ---- 6: sticky overflow ----
        reset = 1'b0;
        wr(0, ins(3'd0, 20)); wr(1, ins(3'd2, 21)); wr(2, ins(3'd0, 21)); wr(3, ins(3'd7, 0));
        wr(20, 8'h7F); wr(21, 8'h01);
        chk("t6_ovf_rst", ovf, 0);
        reset = 1'b1;
        tick(3);
        chk("t6_ovf_load", ovf, 0);
        tick(3);
        chk("t6_acc_80", dataOut, 8'h80);
        chk("t6_ovf_set", ovf, 1);
        tick(6);
        chk("t6_ovf_sticky", ovf, 1);
        reset = 1'b0;
        tick(1);
        chk("t6_ovf_clear", ovf, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
